// File: rtl/data_ram_ws_if.sv
// CPU data-side memory port: request fields driven by the CPU, completion
// and stall signals returned by the memory responder.
interface data_ram_ws_if;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic        stallreq_o;

  modport master (
    output ce_i, we_i, addr_i, sel_i, data_i,
    input  data_o, ack_o, stallreq_o
  );

  modport slave (
    input  ce_i, we_i, addr_i, sel_i, data_i,
    output data_o, ack_o, stallreq_o
  );
endinterface

// File: rtl/data_ram_ws.sv
// Word-wide data memory with byte-enabled writes, a fixed number of wait
// states per access, a one-cycle ack pulse and a pipeline stall request.
module data_ram_ws #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic   clk,
  input  logic   rst,
  data_ram_ws_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q;
  logic                req_we;
  logic [ADDR_W-1:0]   req_idx;
  logic [3:0]          req_sel;
  logic [31:0]         req_data;
  logic [31:0]         rdata_q;
  logic                accept;
  logic                access;
  logic [31:0]         mem [2**ADDR_W];

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.ce_i) begin
        accept  = 1'b1;
        state_d = BUSY;
      end
      BUSY: if (cnt_q == 4'd0) begin
        access  = 1'b1;
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request fields are captured once at acceptance; the bus is ignored afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 4'd0;
      req_we   <= 1'b0;
      req_idx  <= '0;
      req_sel  <= 4'd0;
      req_data <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      if (accept) begin
        cnt_q    <= WAIT_LD;
        req_we   <= bus.we_i;
        req_idx  <= bus.addr_i[ADDR_W+1:2];
        req_sel  <= bus.sel_i;
        req_data <= bus.data_i;
      end else if (state_q == BUSY && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (access && !req_we) rdata_q <= mem[req_idx];
    end
  end

  // Memory contents survive reset; reset only suppresses an in-flight write.
  always_ff @(posedge clk) begin
    if (!rst && access && req_we) begin
      for (int b = 0; b < 4; b++) begin
        if (req_sel[b]) mem[req_idx][8*b +: 8] <= req_data[8*b +: 8];
      end
    end
  end

  assign bus.data_o     = rdata_q;
  assign bus.ack_o      = (state_q == ACK);
  assign bus.stallreq_o = ~rst & (((state_q == IDLE) & bus.ce_i) | (state_q == BUSY));

  logic unused_addr;
  assign unused_addr = ^{bus.addr_i[31:ADDR_W+2], bus.addr_i[1:0]};

endmodule

// File: tb/tb_data_ram_ws.sv
// Bench for data_ram_ws: lane 0 runs with no wait states, lane 1 with two,
// both checked every cycle against a cycle-numbered memory model.
module tb_data_ram_ws;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ce   [2];
  logic        we   [2];
  logic [31:0] addr [2];
  logic [3:0]  sel  [2];
  logic [31:0] wdat [2];
  logic [31:0] dout [2];
  logic        ack  [2];
  logic        stall[2];

  data_ram_ws_if bus0 ();
  data_ram_ws_if bus1 ();

  assign bus0.ce_i = ce[0];  assign bus0.we_i = we[0];  assign bus0.addr_i = addr[0];
  assign bus0.sel_i = sel[0]; assign bus0.data_i = wdat[0];
  assign bus1.ce_i = ce[1];  assign bus1.we_i = we[1];  assign bus1.addr_i = addr[1];
  assign bus1.sel_i = sel[1]; assign bus1.data_i = wdat[1];
  assign dout[0] = bus0.data_o; assign ack[0] = bus0.ack_o; assign stall[0] = bus0.stallreq_o;
  assign dout[1] = bus1.data_o; assign ack[1] = bus1.ack_o; assign stall[1] = bus1.stallreq_o;

  data_ram_ws #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  data_ram_ws #(.ADDR_W(10), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s lane%0d @%0t: got %h expected %h", name, lane, $time, act, exp);
    end
  endtask

  function automatic int wait_of(input int lane);
    return (lane == 0) ? 0 : 2;
  endfunction

  // Model: an accepted request in cycle N acks in cycle N+2+W; the access
  // itself happens at the edge ending cycle N+1+W.
  int          cyc = 0;
  int          ack_at [2];
  logic        m_we   [2];
  int          m_idx  [2];
  logic [3:0]  m_sel  [2];
  logic [31:0] m_dat  [2];
  logic [31:0] exp_d  [2];
  logic [31:0] mm [int];
  bit          armed = 0;

  initial begin
    for (int l = 0; l < 2; l++) begin
      ack_at[l] = -100;
      exp_d[l]  = 32'd0;
    end
    forever begin
      @(negedge clk);
      if (armed) begin
        for (int l = 0; l < 2; l++) begin
          chk("ack", l, {31'd0, ack[l]}, {31'd0, cyc == ack_at[l]});
          chk("stall", l, {31'd0, stall[l]},
              {31'd0, !rst && (cyc < ack_at[l] || (cyc > ack_at[l] && ce[l]))});
          chk("data_o", l, dout[l], exp_d[l]);
        end
      end
      for (int l = 0; l < 2; l++) begin
        if (rst) begin
          ack_at[l] = -100;
          exp_d[l]  = 32'd0;
        end else begin
          if (cyc > ack_at[l] && ce[l]) begin
            m_we[l]   = we[l];
            m_idx[l]  = l * 4096 + int'(addr[l][11:2]);
            m_sel[l]  = sel[l];
            m_dat[l]  = wdat[l];
            ack_at[l] = cyc + 2 + wait_of(l);
          end
          if (cyc + 1 == ack_at[l]) begin
            logic [31:0] w;
            w = mm.exists(m_idx[l]) ? mm[m_idx[l]] : 32'hxxxx_xxxx;
            if (m_we[l]) begin
              for (int b = 0; b < 4; b++)
                if (m_sel[l][b]) w[8*b +: 8] = m_dat[l][8*b +: 8];
              mm[m_idx[l]] = w;
            end else begin
              exp_d[l] = w;
            end
          end
        end
      end
      if (rst) armed = 1;
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_access(input int lane, input logic w, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d, output logic [31:0] rd);
    bit got = 0;
    rd = 32'd0;
    ce[lane] = 1'b1; we[lane] = w; addr[lane] = a; sel[lane] = s; wdat[lane] = d;
    step();
    ce[lane] = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ack[lane]) begin
        got = 1;
        rd  = dout[lane];
      end
    end
    if (!got) chk("ack_timeout", lane, 32'd0, 32'd1);
    step();
  endtask

  logic [31:0] rd;
  int          acks;
  int          ack_cycles[$];

  initial begin
    rst = 1'b1;
    for (int l = 0; l < 2; l++) begin
      ce[l] = 1'b0; we[l] = 1'b0; addr[l] = 32'd0; sel[l] = 4'd0; wdat[l] = 32'd0;
    end
    repeat (3) step();
    chk("reset_data", 1, dout[1], 32'd0);
    chk("reset_ack", 1, {31'd0, ack[1]}, 32'd0);
    rst = 1'b0;
    step();

    // Cycle-exact write, then read back
    ce[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h10; sel[1] = 4'hF; wdat[1] = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_stall_c0", 1, {31'd0, stall[1]}, 32'd1);
    step();
    ce[1] = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("t1_stall", 1, {31'd0, stall[1]}, {31'd0, c <= 3});
      chk("t1_ack", 1, {31'd0, ack[1]}, {31'd0, c == 4});
      step();
    end
    do_access(1, 1'b0, 32'h10, 4'h0, 32'd0, rd);
    chk("t1_read", 1, rd, 32'hDEADBEEF);

    // Byte-enable merge
    do_access(1, 1'b1, 32'h20, 4'hF, 32'h11223344, rd);
    do_access(1, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, rd);
    do_access(1, 1'b0, 32'h20, 4'hF, 32'd0, rd);
    chk("merge", 1, rd, 32'h11BB33DD);

    // Wrap-around and ignored low address bits
    do_access(1, 1'b1, 32'h0000_1004, 4'hF, 32'hCAFEF00D, rd);
    do_access(1, 1'b0, 32'h0000_0006, 4'h0, 32'd0, rd);
    chk("wrap", 1, rd, 32'hCAFEF00D);

    // sel=0 write still acks and changes nothing
    do_access(1, 1'b1, 32'h20, 4'h0, 32'h0, rd);
    do_access(1, 1'b0, 32'h20, 4'hF, 32'd0, rd);
    chk("sel0", 1, rd, 32'h11BB33DD);

    // Inputs changing during BUSY are ignored
    do_access(1, 1'b1, 32'h34, 4'hF, 32'h12345678, rd);
    ce[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h30; sel[1] = 4'hF; wdat[1] = 32'hA5A5A5A5;
    step();
    addr[1] = 32'h34; wdat[1] = 32'd0; ce[1] = 1'b0;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ack[1]) acks++;
      step();
    end
    chk("midchg_acks", 1, 32'(acks), 32'd1);
    do_access(1, 1'b0, 32'h30, 4'hF, 32'd0, rd);
    chk("midchg_30", 1, rd, 32'hA5A5A5A5);
    do_access(1, 1'b0, 32'h34, 4'hF, 32'd0, rd);
    chk("midchg_34", 1, rd, 32'h12345678);

    // Reset during the first BUSY cycle discards the write
    do_access(1, 1'b1, 32'h40, 4'hF, 32'h55555555, rd);
    ce[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h40; sel[1] = 4'hF; wdat[1] = 32'h0;
    step();
    rst = 1'b1; ce[1] = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", 1, {31'd0, ack[1]}, 32'd0);
    chk("rst_data", 1, dout[1], 32'd0);
    chk("rst_stall", 1, {31'd0, stall[1]}, 32'd0);
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      @(negedge clk);
      if (ack[1]) acks++;
    end
    chk("rst_noack", 1, 32'(acks), 32'd0);
    step();
    do_access(1, 1'b0, 32'h40, 4'hF, 32'd0, rd);
    chk("rst_keep", 1, rd, 32'h55555555);

    // Back-to-back reads with zero wait states and ce held high
    for (int i = 0; i < 4; i++)
      do_access(0, 1'b1, 32'(i * 4), 4'hF, 32'h1000_0000 | 32'(i), rd);
    ce[0] = 1'b1; we[0] = 1'b0;
    for (int c = 0; c < 15; c++) begin
      addr[0] = 32'((c % 4) * 4);
      @(negedge clk);
      if (ack[0]) begin
        ack_cycles.push_back(c);
        chk("b2b_data", 0, dout[0], 32'h1000_0000 | 32'((c - 2) % 4));
      end
      step();
    end
    ce[0] = 1'b0;
    chk("b2b_count", 0, 32'(ack_cycles.size()), 32'd5);
    if (ack_cycles.size() > 0) chk("b2b_first", 0, 32'(ack_cycles[0]), 32'd2);
    for (int k = 1; k < ack_cycles.size(); k++)
      chk("b2b_gap", 0, 32'(ack_cycles[k] - ack_cycles[k-1]), 32'd3);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_ram_ws.md
Name: data_ram_ws

Overview:
- Data-memory responder for the CPU's load/store memory-stage port.
- Accepts a word-wide read or byte-enabled write request.
- Inserts a programmable number of wait states, then completes the access with a one-cycle ack pulse.
- Holds the pipeline with a stall request while the access is outstanding.
- Sits beside the instruction ROM in the minimal SoC, on the CPU's data-side bus.

Parameters:
- ADDR_W, 10: log2 of memory depth in 32-bit words (1024 words default).
- WAIT_CYCLES, 2: extra wait states per access; legal range 0..15; 4-bit counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ce_i  input  1  request valid from CPU.
- we_i  input  1  1 = write, 0 = read.
- addr_i  input  32  byte address; word index = addr_i[ADDR_W+1:2].
- sel_i  input  4  byte enables: sel_i[3]->data[31:24], sel_i[2]->[23:16], sel_i[1]->[15:8], sel_i[0]->[7:0].
- data_i  input  32  write data.
- data_o  output  32  read data; valid when ack_o=1 on a read.
- ack_o  output  1  one-cycle completion pulse.
- stallreq_o  output  1  pipeline stall request while the access is outstanding.

Behaviour:
- Reset, applied when rst=1 at an edge:
  - data_o=0, ack_o=0, state=IDLE, counter=0, latched request cleared.
  - stallreq_o=0 while rst=1.
  - Memory array contents are not reset.
- FSM states: IDLE, BUSY, ACK.
- IDLE:
  - ce_i=1 at an edge latches we_i, addr_i, sel_i and data_i, loads counter=WAIT_CYCLES, and moves to BUSY.
  - ce_i=0: stay in IDLE.
- BUSY:
  - Counter != 0: decrement.
  - Counter == 0 at an edge: perform the access using the latched fields, set ack_o=1, move to ACK.
  - Inputs are ignored in BUSY; a change to addr_i, data_i, we_i or sel_i has no effect.
  - ce_i falling mid-access does not abort: the access still completes and ack still pulses.
- ACK:
  - ack_o=1 for this cycle only.
  - Next edge: ack_o=0, return to IDLE.
  - ce_i is ignored in ACK. A held ce_i is accepted as a new request on the following IDLE edge.
- Latency:
  - Request first sampled in IDLE at the end of cycle N -> ack_o high in cycle N+2+WAIT_CYCLES.
  - WAIT_CYCLES=0 -> ack in cycle N+2.
- Throughput: back-to-back requests complete every WAIT_CYCLES+3 cycles.
- stallreq_o (combinational) = (state==IDLE & ce_i & ~rst) | (state==BUSY). It is 0 in the ACK cycle.
- Write:
  - Only the bytes whose latched sel bit is 1 are updated.
  - sel=4'b0000 writes nothing but still acks.
  - data_o is unchanged by writes.
- Read:
  - data_o loads the full 32-bit word at the access edge, regardless of sel.
  - data_o holds that value until the next read completes.
- Addressing:
  - addr_i[1:0] is ignored (no misalignment fault).
  - Bits above ADDR_W+1 are ignored, so addresses wrap modulo 2^ADDR_W words.
- Reset mid-operation: rst takes priority over the access edge. An in-flight write is discarded, and ack_o and data_o return to 0.
- Uninitialised words read as X in simulation. The bench must write before reading.

Test Plan:
- Full write then read, WAIT_CYCLES=2:
  - Write addr 0x0000_0010, sel 4'hF, data 0xDEADBEEF, with ce accepted at end of cycle 0.
  - Required: stallreq_o=1 in cycles 0-3, ack_o=1 in cycle 4 only, stallreq_o=0 in cycle 4.
  - A subsequent read of 0x10 returns data_o=0xDEADBEEF with its ack.
- Byte-enable merge:
  - Preload 0x11223344 at 0x20, then write data 0xAABBCCDD with sel 4'b0101.
  - Required: a read of 0x20 returns 0x11BB33DD.
- Wrap-around and alignment, ADDR_W=10:
  - Write 0xCAFEF00D at 0x0000_1004.
  - Required: a read at 0x0000_0006 returns 0xCAFEF00D (index 1).
- Input change mid-access:
  - Issue a write to 0x30; during BUSY, change addr_i to 0x34, data_i to 0, and drop ce_i.
  - Required: exactly one ack, and 0x30 holds the original data while 0x34 is unchanged.
- Reset mid-write:
  - Preload 0x55555555 at 0x40, then start a write of 0x0 to 0x40 and assert rst in the first BUSY cycle.
  - Required: no ack, data_o=0, stallreq_o=0 after the reset edge, and 0x40 still reads 0x55555555.
- Back-to-back reads with WAIT_CYCLES=0 and ce_i held high:
  - Required: acks occur every 3 cycles, and data_o updates only on ack cycles.
